alu_arbiter: RTL

Shares one ALU instance between NUM_REQ requesters, for example the EX stage and the branch/address-compare unit. Each requester has a valid/ready request channel. The block picks one request per cycle by round-robin and drives it through the ALU combinationally. It captures the result in a one-entry registered response buffer with a valid/ready response channel tagged by requester ID. Sustained throughput is one operation per cycle while the response side is not backpressuring.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu.sv | 34 +++
 rtl/rr_arbiter.sv | 22 ++
 rtl/alu_arbiter.sv | 63 ++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation codes, widths and response-buffer states
package alu_pkg;
  localparam int ALU_CTRL_W = 4;
  localparam int DATA_WIDTH_DEF = 32;
  typedef enum logic [ALU_CTRL_W-1:0] {
    ADD   = 4'b0000,
    SUB   = 4'b0001,
    AND   = 4'b0010,
    OR    = 4'b0011,
    XOR   = 4'b0100,
    SLL   = 4'b0101,
    SRL   = 4'b0110,
    SRA   = 4'b0111,
    SLT   = 4'b1000,
    SLTU  = 4'b1001,
    PASSB = 4'b1111
  } alu_op_e;
  typedef enum logic {RSP_EMPTY, RSP_FULL} rsp_state_e;
endpackage

// File: rtl/alu.sv
// alu: stateless combinational ALU, unknown codes yield zero
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [ALU_CTRL_W-1:0] ctrl,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero
);
  localparam int SW = $clog2(DATA_WIDTH);
  logic [SW-1:0] sh;
  assign sh = b[SW-1:0];
  always_comb begin
    result = '0;
    case (ctrl)
      ADD:   result = a + b;
      SUB:   result = a - b;
      AND:   result = a & b;
      OR:    result = a | b;
      XOR:   result = a ^ b;
      SLL:   result = a << sh;
      SRL:   result = a >> sh;
      SRA:   result = $signed(a) >>> sh;
      SLT:   result = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      SLTU:  result = {{(DATA_WIDTH-1){1'b0}}, a < b};
      PASSB: result = b;
      default: result = '0;
    endcase
  end
  assign zero = result == '0;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (en && req[(int'(ptr) + i) % NUM_REQ]) begin
        gnt = NUM_REQ'(1) << ((int'(ptr) + i) % NUM_REQ);
        idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU behind a one-entry registered response buffer
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_REQ = 2,
  parameter int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srca_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srcb_i,
  input  logic [NUM_REQ*ALU_CTRL_W-1:0]    req_ctrl_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [DATA_WIDTH-1:0]            rsp_result_o,
  output logic                             rsp_zero_o,
  output logic [ID_W-1:0]                  rsp_id_o
);
  rsp_state_e state;
  logic [ID_W-1:0] ptr, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic can_accept, accept, alu_zero;
  logic [DATA_WIDTH-1:0] alu_result;
  assign can_accept = (state == RSP_EMPTY) || rsp_ready_i;
  assign accept = |gnt;
  assign req_ready_o = gnt;
  assign rsp_valid_o = state == RSP_FULL;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req(req_valid_i),
    .ptr(ptr),
    .en(can_accept),
    .gnt(gnt),
    .idx(gnt_idx)
  );
  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .ctrl(req_ctrl_i[gnt_idx*ALU_CTRL_W +: ALU_CTRL_W]),
    .a(req_srca_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH]),
    .b(req_srcb_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH]),
    .result(alu_result),
    .zero(alu_zero)
  );
  // A full buffer reloads in the same cycle it drains, keeping one op per cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= RSP_EMPTY;
      ptr <= '0;
      rsp_result_o <= '0;
      rsp_zero_o <= 1'b0;
      rsp_id_o <= '0;
    end else if (accept) begin
      state <= RSP_FULL;
      ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
      rsp_result_o <= alu_result;
      rsp_zero_o <= alu_zero;
      rsp_id_o <= gnt_idx;
    end else if (rsp_ready_i) begin
      state <= RSP_EMPTY;
    end
  end
endmodule
